sdram_read_to_avalon_st: RTL
============================

# sdram_read_to_avalon_st

Reads 8-beat, 256-bit bursts from SDRAM over an Avalon-MM read master and streams the returned data out on an Avalon-ST source. It is the read-side counterpart of the SDRAM write path and sits between the DDR/SDRAM controller and the accelerator's data-input stream. Each 32-bit instruction word names the burst's byte address. Returned data is byte-reversed and buffered in an internal FIFO, so downstream backpressure never stalls the non-stallable `readdatavalid` path.

## Interface
- `BURST_LEN`, 8: beats per burst; drives `mm_burstcount`.
- `FIFO_DEPTH`, 16: FIFO depth in beats; power of two, ≥ `BURST_LEN`.
- `clock`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `mm_addr`  out  27  word address; equals instruction bits [31:5].
- `mm_byteenable`  out  32  all-ones while reading.
- `mm_burstcount`  out  8  equals `BURST_LEN`.
- `mm_read`  out  1  read command.
- `mm_waitrequest`  in  1  slave stall.
- `mm_readdata`  in  256  returned beat.
- `mm_readdatavalid`  in  1  returned beat is valid.
- `st_instruction_valid` / `st_instruction_ready`  in / out  1  instruction handshake.
- `st_instruction_data`  in  32  byte address; 0 means no-op.
- `st_valid`  out  1  output beat available.
- `st_data`  out  256  output beat, byte-reversed.
- `st_ready`  in  1  downstream accepts.
- `csr_address`  in  4  CSR select.
- `csr_read`  in  1  unused; CSR is refreshed every cycle.
- `csr_readdata`  out  32  registered CSR value.

## Operation
- States are `IDLE`=0, `REQUEST`=1, `RECEIVING`=2. Only one burst is outstanding at a time.
- `space_ok` = (`FIFO_DEPTH` − `fifo_count`) ≥ `BURST_LEN`. It uses the current count; a pop in the same cycle is ignored (conservative).
- `st_instruction_ready` (combinational) is asserted when either:
  - `st_instruction_valid` && data==0, in any state (no-op, dropped); or
  - `IDLE` && `st_instruction_valid` && data≠0 && `space_ok`.
- Accepting a non-zero instruction:
  - loads `mm_addr`←data[31:5], `mm_byteenable`←all-ones, `mm_burstcount`←`BURST_LEN`;
  - sets `mm_read`←1 and `beat_cnt`←0;
  - moves to `REQUEST`.
- `REQUEST`: `mm_read` and the address stay stable while `mm_waitrequest`=1. In the first cycle with `mm_waitrequest`=0, the command is taken, `mm_read`←0, and the state moves to `RECEIVING`.
- `RECEIVING`: each `mm_readdatavalid` pushes the byte-swapped beat and increments `beat_cnt`. When `beat_cnt`==`BURST_LEN`−1 and a beat arrives, the state moves to `IDLE`.
- Byte swap: output byte i (bits 8i+7:8i) = `mm_readdata` byte 31−i.
- A `readdatavalid` outside `RECEIVING` is a stray beat:
  - it is dropped;
  - `stray_cnt` increments, saturating at 0xFFFF;
  - sticky `err` is set.
- Overflow (a push while the FIFO is full) cannot occur under `space_ok`. If it does occur, the beat is dropped and `err` is set.
- FIFO is show-ahead: `st_valid` = !empty and `st_data` = head. A pop happens when `st_valid` && `st_ready`. A simultaneous push and pop leaves the count unchanged. Pointers wrap modulo `FIFO_DEPTH`; the count is `log2(FIFO_DEPTH)`+1 bits.
- `checksum` accumulates, on every pushed beat, the sum of its eight swapped 32-bit words, wrapping mod 2^32.
- CSR map (registered):
  - 0: state
  - 4: `checksum`
  - 8: `mm_addr` (zero-extended)
  - 12: {`err`, `mm_read`, `mm_waitrequest`, `mm_readdatavalid`, `st_instruction_valid`, `st_instruction_ready`, `st_valid`, `st_ready`} in bits [7:0]
  - 16: {`stray_cnt`, `fifo_count`} (`stray_cnt` in [31:16], `fifo_count` in [15:0])
  - otherwise: 0xDEADBEEF
- Reset:
  - all outputs go to 0; state→`IDLE`;
  - FIFO is emptied; `checksum`, `stray_cnt`, `err` are cleared;
  - a reset mid-burst abandons the burst, and its late beats count as stray.

## Timing
- Instruction accept to `mm_read` high: 1 cycle (registered).
- `mm_read` falls the cycle after the `waitrequest`=0 edge.
- `readdatavalid` to beat visible on `st_valid`/`st_data`: 1 cycle.
- `st_valid` falls the cycle after the last pop.
- After the final beat, the state is `IDLE` next cycle. The next `mm_read` rises no earlier than 2 cycles after that final beat.
- `csr_readdata` reflects state from 1 cycle earlier.
- Beats may arrive back-to-back or with gaps. Every beat is captured regardless of `st_ready`.

## Test plan
- Instruction 0x0000_1000, `waitrequest` low, 8 back-to-back beats, `st_ready`=1 → `mm_addr`=0x80, `mm_burstcount`=8, 8 outputs byte-reversed in order, state back to 0, CSR 4 = sum of words.
- `waitrequest` held 5 cycles → `mm_read` and `mm_addr` held stable for 6 cycles, then `mm_read` drops; exactly one command is issued.
- `st_ready`=0 through two bursts (`FIFO_DEPTH`=16) → FIFO reaches 16; a third instruction is not accepted until 8 pops have occurred; no beats are lost.
- Instruction data 0 in `RECEIVING` → ready=1 the same cycle, no `mm_read`, burst unaffected.
- Reset asserted after 3 beats, then 5 more beats arrive → outputs 0, `st_valid`=0, CSR 16 `stray_cnt`=5, `err`=1.
- Random `readdatavalid` gaps and random `st_ready` over 100 bursts → output sequence matches a reference model, and the checksum matches.

Source files
------------

// File: rtl/sdram_read_to_avalon_st.sv
// Issues 8-beat SDRAM read bursts from 32-bit instruction words and streams the
// byte-reversed return data out of a show-ahead FIFO on an Avalon-ST source.
module sdram_read_to_avalon_st #(
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  output logic [26:0]  mm_addr,
  output logic [31:0]  mm_byteenable,
  output logic [7:0]   mm_burstcount,
  output logic         mm_read,
  input  logic         mm_waitrequest,
  input  logic [255:0] mm_readdata,
  input  logic         mm_readdatavalid,
  input  logic         st_instruction_valid,
  output logic         st_instruction_ready,
  input  logic [31:0]  st_instruction_data,
  output logic         st_valid,
  output logic [255:0] st_data,
  input  logic         st_ready,
  input  logic [3:0]   csr_address,
  input  logic         csr_read,
  output logic [31:0]  csr_readdata
);

  localparam int unsigned DATA_W = 256;
  localparam int unsigned BYTES  = DATA_W / 8;
  localparam int unsigned WORDS  = DATA_W / 32;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQUEST   = 2'd1,
    RECEIVING = 2'd2
  } state_t;

  state_t              r_state;
  logic [26:0]         r_mm_addr;
  logic [31:0]         r_mm_byteenable;
  logic [7:0]          r_mm_burstcount;
  logic                r_mm_read;
  logic [BEAT_W-1:0]   r_beat_cnt;
  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [31:0]         r_checksum;
  logic [15:0]         r_stray_cnt;
  logic                r_err;
  logic [31:0]         r_csr_readdata;

  logic [DATA_W-1:0]   w_swapped;
  logic [31:0]         w_beat_sum;
  logic                w_is_noop;
  logic                w_space_ok;
  logic                w_accept;
  logic                w_full;
  logic                w_push_req;
  logic                w_push;
  logic                w_pop;
  logic                w_stray;
  logic                w_unused_csr_read;

  assign w_unused_csr_read = csr_read;

  // Byte reversal of the returned beat and the sum of its 32-bit words
  always_comb begin
    w_swapped = '0;
    for (int i = 0; i < BYTES; i++) begin
      w_swapped[8*i +: 8] = mm_readdata[8*(BYTES-1-i) +: 8];
    end
  end

  always_comb begin
    w_beat_sum = '0;
    for (int i = 0; i < WORDS; i++) begin
      w_beat_sum = w_beat_sum + w_swapped[32*i +: 32];
    end
  end

  // Room check ignores a same-cycle pop, so a whole burst always fits
  assign w_space_ok = (CNT_W'(FIFO_DEPTH) - r_count) >= CNT_W'(BURST_LEN);
  assign w_is_noop  = (st_instruction_data == 32'd0);
  assign w_accept   = st_instruction_valid && !w_is_noop && (r_state == IDLE) && w_space_ok;
  assign st_instruction_ready = st_instruction_valid &&
                                (w_is_noop || ((r_state == IDLE) && w_space_ok));

  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push_req = mm_readdatavalid && (r_state == RECEIVING);
  assign w_push     = w_push_req && !w_full;
  assign w_stray    = mm_readdatavalid && (r_state != RECEIVING);
  assign w_pop      = st_valid && st_ready;

  assign mm_addr       = r_mm_addr;
  assign mm_byteenable = r_mm_byteenable;
  assign mm_burstcount = r_mm_burstcount;
  assign mm_read       = r_mm_read;
  assign st_valid      = (r_count != '0);
  assign st_data       = st_valid ? r_mem[r_rd_ptr] : '0;
  assign csr_readdata  = r_csr_readdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_mm_addr       <= '0;
      r_mm_byteenable <= '0;
      r_mm_burstcount <= '0;
      r_mm_read       <= 1'b0;
      r_beat_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mm_addr       <= st_instruction_data[31:5];
            r_mm_byteenable <= '1;
            r_mm_burstcount <= 8'(BURST_LEN);
            r_mm_read       <= 1'b1;
            r_beat_cnt      <= '0;
            r_state         <= REQUEST;
          end
        end
        REQUEST: begin
          if (!mm_waitrequest) begin
            r_mm_read <= 1'b0;
            r_state   <= RECEIVING;
          end
        end
        RECEIVING: begin
          if (mm_readdatavalid) begin
            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            if (r_beat_cnt == BEAT_W'(BURST_LEN - 1)) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // FIFO storage needs no reset: st_data is masked while empty
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_swapped;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_checksum  <= '0;
      r_stray_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
        r_checksum <= r_checksum + w_beat_sum;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_stray && (r_stray_cnt != 16'hFFFF)) begin
        r_stray_cnt <= r_stray_cnt + 16'd1;
      end
      if (w_stray || (w_push_req && w_full)) begin
        r_err <= 1'b1;
      end
    end
  end

  // csr_address is a word index: byte offset = 4 * csr_address
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_csr_readdata <= '0;
    end else begin
      case (csr_address)
        4'd0:    r_csr_readdata <= {30'd0, r_state};
        4'd1:    r_csr_readdata <= r_checksum;
        4'd2:    r_csr_readdata <= 32'(r_mm_addr);
        4'd3:    r_csr_readdata <= {24'd0, r_err, r_mm_read, mm_waitrequest, mm_readdatavalid,
                                    st_instruction_valid, st_instruction_ready, st_valid, st_ready};
        4'd4:    r_csr_readdata <= {r_stray_cnt, 16'(r_count)};
        default: r_csr_readdata <= 32'hDEADBEEF;
      endcase
    end
  end

endmodule
